// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Purpose  : Main control FSM for the multicycle MIPS datapath. Sequences
//            fetch / decode / execute / memory / writeback for each
//            instruction from the IR opcode. Drives all datapath mux selects
//            and write enables, and stalls on the memory handshake. Produces
//            the 2-bit alu_Op consumed by alu_control_unit
//            (00 add, 01 subtract, 10 decode function field).
// Config   : ADDI_EN -- when defined, addi is decoded and the ADDI_EXEC and
//            ADDI_WB states are live. When undefined, addi raises illegal_op
//            and codes 10/11 behave like the unused codes 12-15.
// Ports    : clk, reset (sync, active-high)
//            opcode[5:0]   IR[31:26], stable from the end of FETCH
//            mem_ready     memory access completes in the cycle it is high
//            pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
//            alu_Op[1:0], pc_source[1:0]   datapath controls
//            illegal_op    one-cycle pulse for an unsupported opcode in DECODE
//            state[3:0]    current state code (debug)
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_Op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_DECODE     = 4'd1,
    S_MEM_ADDR   = 4'd2,
    S_MEM_READ   = 4'd3,
    S_MEM_WB     = 4'd4,
    S_MEM_WRITE  = 4'd5,
    S_EXECUTE    = 4'd6,
    S_R_COMPLETE = 4'd7,
    S_BRANCH     = 4'd8,
    S_JUMP       = 4'd9,
    S_ADDI_EXEC  = 4'd10,
    S_ADDI_WB    = 4'd11
  } state_t;

  state_t r_state;
  state_t w_next_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  assign state = r_state;

  always_comb begin
    w_next_state  = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_Op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;

    case (r_state)
      S_FETCH: begin
        // PC+4 and IR load only commit in the cycle the read completes;
        // the read request itself is held steady through the stall.
        mem_read     = 1'b1;
        alu_src_b    = 2'b01;
        ir_write     = mem_ready;
        pc_write     = mem_ready;
        w_next_state = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: w_next_state = S_MEM_ADDR;
          OP_RTYPE:     w_next_state = S_EXECUTE;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_J:         w_next_state = S_JUMP;
`ifdef ADDI_EN
          OP_ADDI:      w_next_state = S_ADDI_EXEC;
`else
          OP_ADDI:      illegal_op   = 1'b1;
`endif
          default:      illegal_op   = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        w_next_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_read     = 1'b1;
        i_or_d       = 1'b1;
        w_next_state = mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write    = 1'b1;
        i_or_d       = 1'b1;
        w_next_state = mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_EXECUTE: begin
        alu_src_a    = 1'b1;
        alu_Op       = 2'b10;
        w_next_state = S_R_COMPLETE;
      end
      S_R_COMPLETE: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_Op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
`ifdef ADDI_EN
      S_ADDI_EXEC: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        w_next_state = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
      end
`endif
      default: begin
        // Unused codes: outputs stay at their defaults, recover to FETCH.
      end
    endcase

    // Reset blanks every control so an aborted instruction cannot write.
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_Op        = 2'b00;
      pc_source     = 2'b00;
      illegal_op    = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_unit
// Purpose  : Self-checking bench for multicycle_control_unit. Directed
//            instruction sequences followed by randomized opcode / mem_ready /
//            reset traffic, compared every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_Op, pc_source;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_Op(alu_Op),
    .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
  );

  int checks = 0;
  int failures = 0;

  // Model: current state code (-1 = unknown before first reset edge) and
  // the remaining state codes of the instruction after DECODE.
  int exp_state = -1;
  int plan[$];

  int tr_state[$], tr_all[$], tr_aluop[$], tr_m2r[$], tr_ill[$], tr_wr[$];
  int tr_mrd[$], tr_asb[$], tr_pwc[$], tr_psrc[$], tr_rw[$], tr_rdst[$], tr_mw[$];

  function automatic bit is_legal(input logic [5:0] op);
    bit ok;
    ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
         (op == OP_BEQ) || (op == OP_J);
`ifdef ADDI_EN
    ok = ok || (op == OP_ADDI);
`endif
    return ok;
  endfunction

  function automatic logic [16:0] model_out();
    logic e_pw, e_pwc, e_iod, e_mrd, e_mw, e_irw, e_m2r, e_rd, e_rw, e_asa, e_ill;
    logic [1:0] e_asb, e_aop, e_psrc;
    {e_pw, e_pwc, e_iod, e_mrd, e_mw, e_irw, e_m2r, e_rd, e_rw, e_asa, e_ill} = '0;
    e_asb = 2'b00; e_aop = 2'b00; e_psrc = 2'b00;
    if (!reset) begin
      case (exp_state)
        0:  begin e_mrd = 1; e_asb = 2'b01; e_irw = mem_ready; e_pw = mem_ready; end
        1:  begin e_asb = 2'b11; e_ill = !is_legal(opcode); end
        2:  begin e_asa = 1; e_asb = 2'b10; end
        3:  begin e_mrd = 1; e_iod = 1; end
        4:  begin e_rw = 1; e_m2r = 1; end
        5:  begin e_mw = 1; e_iod = 1; end
        6:  begin e_asa = 1; e_aop = 2'b10; end
        7:  begin e_rw = 1; e_rd = 1; end
        8:  begin e_asa = 1; e_aop = 2'b01; e_pwc = 1; e_psrc = 2'b01; end
        9:  begin e_pw = 1; e_psrc = 2'b10; end
`ifdef ADDI_EN
        10: begin e_asa = 1; e_asb = 2'b10; end
        11: begin e_rw = 1; end
`endif
        default: ;
      endcase
    end
    return {e_pw, e_pwc, e_iod, e_mrd, e_mw, e_irw, e_m2r, e_rd, e_rw, e_asa,
            e_asb, e_aop, e_psrc, e_ill};
  endfunction

  task automatic model_step();
    if (reset) begin
      exp_state = 0;
      plan.delete();
    end else if (exp_state < 0) begin
      exp_state = -1;
    end else if ((exp_state == 0 || exp_state == 3 || exp_state == 5) && !mem_ready) begin
      exp_state = exp_state;
    end else if (exp_state == 0) begin
      exp_state = 1;
    end else begin
      if (exp_state == 1) begin
        plan.delete();
        if (opcode == OP_LW) plan = '{2, 3, 4};
        else if (opcode == OP_SW) plan = '{2, 5};
        else if (opcode == OP_RTYPE) plan = '{6, 7};
        else if (opcode == OP_BEQ) plan = '{8};
        else if (opcode == OP_J) plan = '{9};
`ifdef ADDI_EN
        else if (opcode == OP_ADDI) plan = '{10, 11};
`endif
      end
      exp_state = (plan.size() > 0) ? plan.pop_front() : 0;
    end
  endtask

  task automatic check_now();
    logic [16:0] act, expv;
    act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_Op,
           pc_source, illegal_op};
    expv = model_out();
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL outputs t=%0t model_state=%0d actual=%h required=%h",
               $time, exp_state, act, expv);
    end
    if (exp_state >= 0) begin
      checks++;
      if (state !== 4'(exp_state)) begin
        failures++;
        $display("FAIL state t=%0t actual=%0d required=%0d", $time, state, exp_state);
      end
    end
    tr_state.push_back(int'(state));
    tr_all.push_back(int'(act));
    tr_aluop.push_back(int'(alu_Op));
    tr_m2r.push_back(int'(mem_to_reg));
    tr_ill.push_back(int'(illegal_op));
    tr_wr.push_back(int'(pc_write | pc_write_cond | mem_write | reg_write | ir_write));
    tr_mrd.push_back(int'(mem_read));
    tr_asb.push_back(int'(alu_src_b));
    tr_pwc.push_back(int'(pc_write_cond));
    tr_psrc.push_back(int'(pc_source));
    tr_rw.push_back(int'(reg_write));
    tr_rdst.push_back(int'(reg_dst));
    tr_mw.push_back(int'(mem_write));
  endtask

  task automatic clear_traces();
    tr_state.delete(); tr_all.delete(); tr_aluop.delete(); tr_m2r.delete();
    tr_ill.delete(); tr_wr.delete(); tr_mrd.delete(); tr_asb.delete();
    tr_pwc.delete(); tr_psrc.delete(); tr_rw.delete(); tr_rdst.delete();
    tr_mw.delete();
  endtask

  task automatic cycle(input logic [5:0] opc, input logic mr, input logic rs);
    opcode = opc; mem_ready = mr; reset = rs;
    @(negedge clk);
    check_now();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [63:0] pack4(input int q[$]);
    logic [63:0] w;
    w = '0;
    foreach (q[i]) w = (w << 4) | 64'(q[i] & 15);
    return w;
  endfunction

  initial begin
    // Reset, then FETCH after release (held in FETCH by mem_ready=0).
    clear_traces();
    cycle(OP_RTYPE, 1'b0, 1'b1);
    cycle(OP_RTYPE, 1'b0, 1'b1);
    cycle(OP_RTYPE, 1'b0, 1'b0);
    lit("reset_outputs", 64'(tr_all[1]), 64'd0);
    lit("reset_state", 64'(tr_state[1]), 64'd0);
    lit("fetch_mem_read", 64'(tr_mrd[2]), 64'd1);
    lit("fetch_alu_src_b", 64'(tr_asb[2]), 64'd1);

    // R-type
    clear_traces();
    repeat (4) cycle(OP_RTYPE, 1'b1, 1'b0);
    cycle(OP_RTYPE, 1'b0, 1'b0);
    lit("rtype_states", pack4(tr_state), 64'h01670);
    lit("rtype_alu_op", 64'(tr_aluop[2]), 64'd2);
    lit("rtype_reg_write", 64'(tr_rw[3]), 64'd1);
    lit("rtype_reg_dst", 64'(tr_rdst[3]), 64'd1);

    // lw with two stall cycles in MEM_READ
    clear_traces();
    cycle(OP_LW, 1'b1, 1'b0); cycle(OP_LW, 1'b1, 1'b0); cycle(OP_LW, 1'b1, 1'b0);
    cycle(OP_LW, 1'b0, 1'b0); cycle(OP_LW, 1'b0, 1'b0); cycle(OP_LW, 1'b1, 1'b0);
    cycle(OP_LW, 1'b1, 1'b0); cycle(OP_LW, 1'b0, 1'b0);
    lit("lw_states", pack4(tr_state), 64'h01233340);
    lit("lw_mem_to_reg", pack4(tr_m2r), 64'h00000010);

    // beq and j
    clear_traces();
    repeat (3) cycle(OP_BEQ, 1'b1, 1'b0);
    cycle(OP_BEQ, 1'b0, 1'b0);
    lit("beq_states", pack4(tr_state), 64'h0180);
    lit("beq_alu_op", 64'(tr_aluop[2]), 64'd1);
    lit("beq_pc_write_cond", 64'(tr_pwc[2]), 64'd1);
    lit("beq_pc_source", 64'(tr_psrc[2]), 64'd1);
    clear_traces();
    repeat (3) cycle(OP_J, 1'b1, 1'b0);
    cycle(OP_J, 1'b0, 1'b0);
    lit("j_states", pack4(tr_state), 64'h0190);
    lit("j_pc_source", 64'(tr_psrc[2]), 64'd2);

    // Illegal opcode
    clear_traces();
    cycle(6'b111111, 1'b1, 1'b0); cycle(6'b111111, 1'b1, 1'b0);
    cycle(6'b111111, 1'b0, 1'b0);
    lit("illegal_states", pack4(tr_state), 64'h010);
    lit("illegal_pulse", pack4(tr_ill), 64'h010);
    lit("illegal_no_write_decode", 64'(tr_wr[1]), 64'd0);
    lit("illegal_no_write_after", 64'(tr_wr[2]), 64'd0);

    // addi
    clear_traces();
`ifdef ADDI_EN
    repeat (4) cycle(OP_ADDI, 1'b1, 1'b0);
    cycle(OP_ADDI, 1'b0, 1'b0);
    lit("addi_states", pack4(tr_state), 64'h01AB0);
    lit("addi_reg_write", 64'(tr_rw[3]), 64'd1);
`else
    cycle(OP_ADDI, 1'b1, 1'b0); cycle(OP_ADDI, 1'b1, 1'b0);
    cycle(OP_ADDI, 1'b0, 1'b0);
    lit("addi_states", pack4(tr_state), 64'h010);
    lit("addi_illegal_pulse", pack4(tr_ill), 64'h010);
`endif

    // Reset during MEM_WRITE with mem_ready high
    clear_traces();
    repeat (3) cycle(OP_SW, 1'b1, 1'b0);
    cycle(OP_SW, 1'b1, 1'b1);
    cycle(OP_SW, 1'b0, 1'b0);
    lit("sw_reset_states", pack4(tr_state), 64'h01250);
    lit("sw_reset_mem_write", 64'(tr_mw[3]), 64'd0);

    // Randomized traffic; opcode only changes while the model is in FETCH.
    begin
      logic [5:0] cur_op;
      cur_op = OP_RTYPE;
      for (int n = 0; n < 3000; n++) begin
        if (exp_state == 0) begin
          case ($urandom_range(0, 6))
            0: cur_op = OP_RTYPE;
            1: cur_op = OP_LW;
            2: cur_op = OP_SW;
            3: cur_op = OP_BEQ;
            4: cur_op = OP_J;
            5: cur_op = OP_ADDI;
            default: cur_op = 6'($urandom_range(0, 63));
          endcase
        end
        clear_traces();
        cycle(cur_op, ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
